// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
// State encoding, parity modes and the 16x oversampling reference points.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    DONE,
    BREAK
  } rxState_t;

  typedef enum logic [1:0] {
    PAR_NONE = 2'b00,
    PAR_ODD  = 2'b01,
    PAR_EVEN = 2'b10,
    PAR_INV  = 2'b11
  } par_t;

  // Mid-bit and end-of-bit tick indices for 16x oversampling.
  localparam int SAMPLE_MID = 7;
  localparam int SAMPLE_END = 15;

  // 7-bit frames shift in from the top, so the payload sits in sh[7:1].
  function automatic logic [7:0] frameData(input logic [7:0] sh, input logic eightBits);
    return eightBits ? sh : {1'b0, sh[7:1]};
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Multi-flop synchronizer for the asynchronous rxd line.
// Flops come out of reset at 1 so an idle line never looks like a start bit.
module uart_rx_sync #(
  parameter int SYNC_FF = 2
) (
  input  logic clk_50mhz,
  input  logic n_rst,
  input  logic rxd,
  output logic rxdSync
);

  logic [SYNC_FF-1:0] syncReg;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk_50mhz or negedge n_rst) begin
    if (!n_rst) syncReg <= '1;
    else        syncReg <= {syncReg[SYNC_FF-2:0], rxd};
  end

  assign rxdSync = syncReg[SYNC_FF-1];

endmodule

// File: rtl/uart_rcvr.sv
// UART receiver: oversampled frame recovery with parity/framing checks,
// one {fe,pe,data} word per frame to the RxFIFO, overrun pulse when it is full.
module uart_rcvr
  import uart_pkg::*;
#(
  parameter int SAMPLE  = 16,
  parameter int SYNC_FF = 2
) (
  input  logic       clk_50mhz,
  input  logic       n_rst,
  input  logic       rxd,
  input  logic       sample_tick,
  input  logic       d_num,
  input  logic       s_num,
  input  logic [1:0] par,
  input  logic       rxfifo_full,
  output logic [9:0] rx_dout,
  output logic       rx_wr,
  output logic       oe_pulse,
  output logic       rx_busy
);

  localparam int TICK_W = $clog2(SAMPLE);
  // Package reference points are for 16x; scale them to the configured rate.
  localparam logic [TICK_W-1:0] MID_CNT = TICK_W'((SAMPLE_MID + 1) * SAMPLE / (SAMPLE_END + 1) - 1);
  localparam logic [TICK_W-1:0] END_CNT = TICK_W'((SAMPLE_END + 1) * SAMPLE / (SAMPLE_END + 1) - 1);

  rxState_t          state, stateNext;
  logic              rxdSync;
  logic [TICK_W-1:0] tickCnt;
  logic [2:0]        bitCnt;
  logic [7:0]        shReg;
  logic              feReg, peReg;
  logic              dNumL, sNumL;
  par_t              parL;
  logic [7:0]        rxData;
  logic              midHit, endHit, startOk, lastData, parOn;

  uart_rx_sync #(.SYNC_FF(SYNC_FF)) u_sync (
    .clk_50mhz (clk_50mhz),
    .n_rst     (n_rst),
    .rxd       (rxd),
    .rxdSync   (rxdSync)
  );

  assign midHit   = sample_tick && (tickCnt == MID_CNT);
  assign endHit   = sample_tick && (tickCnt == END_CNT);
  assign startOk  = (state == START) && midHit && !rxdSync;
  assign lastData = bitCnt == (dNumL ? 3'd7 : 3'd6);
  assign parOn    = (parL == PAR_ODD) || (parL == PAR_EVEN);
  assign rxData   = frameData(shReg, dNumL);

  always_ff @(posedge clk_50mhz or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= stateNext;
  end

  // NOTE: every output of this block is defaulted first so no path infers a latch.
  always_comb begin
    stateNext = state;
    rx_wr     = 1'b0;
    oe_pulse  = 1'b0;
    rx_dout   = '0;
    rx_busy   = (state != IDLE);
    unique case (state)
      IDLE:   if (!rxdSync) stateNext = START;
      START:  if (midHit) stateNext = rxdSync ? IDLE : DATA;
      DATA:   if (endHit && lastData) stateNext = parOn ? PARITY : STOP;
      PARITY: if (endHit) stateNext = STOP;
      STOP:   if (endHit && !(sNumL && bitCnt == 3'd0)) stateNext = DONE;
      DONE: begin
        rx_wr     = !rxfifo_full;
        oe_pulse  = rxfifo_full;
        rx_dout   = rxfifo_full ? 10'd0 : {feReg, peReg, rxData};
        stateNext = rxdSync ? IDLE : BREAK;
      end
      BREAK:  if (rxdSync) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Frame configuration is captured at start confirm and held for the whole frame.
  always_ff @(posedge clk_50mhz or negedge n_rst) begin
    if (!n_rst) begin
      tickCnt <= '0;
      bitCnt  <= '0;
      shReg   <= '0;
      feReg   <= 1'b0;
      peReg   <= 1'b0;
      dNumL   <= 1'b1;
      sNumL   <= 1'b0;
      parL    <= PAR_NONE;
    end else begin
      if (state == IDLE)    tickCnt <= '0;
      else if (sample_tick) tickCnt <= (tickCnt == END_CNT) ? '0 : tickCnt + 1'b1;

      if (startOk) begin
        tickCnt <= '0;
        bitCnt  <= '0;
        shReg   <= '0;
        feReg   <= 1'b0;
        peReg   <= 1'b0;
        dNumL   <= d_num;
        sNumL   <= s_num;
        parL    <= par_t'(par);
      end

      if (state == DATA && endHit) begin
        shReg  <= {rxdSync, shReg[7:1]};
        bitCnt <= lastData ? 3'd0 : bitCnt + 1'b1;
      end

      if (state == PARITY && endHit)
        peReg <= (parL == PAR_EVEN) ? (^rxData ^ rxdSync) : ~(^rxData ^ rxdSync);

      if (state == STOP && endHit) begin
        feReg  <= feReg | ~rxdSync;
        bitCnt <= bitCnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_rcvr.sv
// Directed testbench for uart_rcvr: one task per scenario, inline checks,
// single summary line at the end.
module tb_uart_rcvr;

  localparam int TICK_CLKS = 4;
  localparam int BIT_CLKS  = 16 * TICK_CLKS;

  logic       clk_50mhz = 1'b0;
  logic       n_rst = 1'b0;
  logic       rxd = 1'b1;
  logic       sample_tick = 1'b0;
  logic       d_num = 1'b1;
  logic       s_num = 1'b0;
  logic [1:0] par = 2'b00;
  logic       rxfifo_full = 1'b0;
  logic [9:0] rx_dout;
  logic       rx_wr;
  logic       oe_pulse;
  logic       rx_busy;

  int testsRun = 0;
  int testsFailed = 0;
  int wrCount = 0;
  int oeCount = 0;
  logic [9:0] lastDout = '0;

  uart_rcvr dut (
    .clk_50mhz   (clk_50mhz),
    .n_rst       (n_rst),
    .rxd         (rxd),
    .sample_tick (sample_tick),
    .d_num       (d_num),
    .s_num       (s_num),
    .par         (par),
    .rxfifo_full (rxfifo_full),
    .rx_dout     (rx_dout),
    .rx_wr       (rx_wr),
    .oe_pulse    (oe_pulse),
    .rx_busy     (rx_busy)
  );

  always #10 clk_50mhz = ~clk_50mhz;

  initial begin
    forever begin
      repeat (TICK_CLKS - 1) @(posedge clk_50mhz);
      #1 sample_tick = 1'b1;
      @(posedge clk_50mhz);
      #1 sample_tick = 1'b0;
    end
  end

  // Counts strobe cycles, so a strobe held for two clocks shows up as +2.
  always @(negedge clk_50mhz) begin
    if (rx_wr) begin
      wrCount  = wrCount + 1;
      lastDout = rx_dout;
    end
    if (oe_pulse) oeCount = oeCount + 1;
  end

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk_50mhz);
    #1;
  endtask

  task automatic send_bit(input logic b);
    rxd = b;
    wait_clks(BIT_CLKS);
  endtask

  task automatic send_frame(input logic [7:0] d, input int nbits, input logic withPar,
                            input logic pbit, input int nstop, input logic stop2);
    send_bit(1'b0);
    for (int i = 0; i < nbits; i++) send_bit(d[i]);
    if (withPar) send_bit(pbit);
    send_bit(1'b1);
    if (nstop == 2) send_bit(stop2);
    rxd = 1'b1;
    wait_clks(2 * BIT_CLKS);
  endtask

  task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic test_reset;
    n_rst = 1'b0;
    wait_clks(3);
    testsRun++;
    if (rx_wr !== 1'b0) begin testsFailed++; $display("FAIL reset_rx_wr: got %b expected 0", rx_wr); end
    testsRun++;
    if (oe_pulse !== 1'b0) begin testsFailed++; $display("FAIL reset_oe: got %b expected 0", oe_pulse); end
    testsRun++;
    if (rx_busy !== 1'b0) begin testsFailed++; $display("FAIL reset_busy: got %b expected 0", rx_busy); end
    testsRun++;
    if (rx_dout !== 10'h000) begin testsFailed++; $display("FAIL reset_dout: got %h expected 000", rx_dout); end
    n_rst = 1'b1;
    wait_clks(BIT_CLKS);
  endtask

  task automatic test_8n1;
    int w0, o0;
    w0 = wrCount; o0 = oeCount;
    d_num = 1'b1; s_num = 1'b0; par = 2'b00;
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1, 1'b1);
    check_val("8n1_wr_count", wrCount - w0, 1);
    check_val("8n1_dout", lastDout, 10'h0A5);
    check_val("8n1_no_oe", oeCount - o0, 0);
    check_val("8n1_busy_idle", rx_busy, 1'b0);
  endtask

  task automatic test_7e1_parity_error;
    int w0;
    w0 = wrCount;
    d_num = 1'b0; s_num = 1'b0; par = 2'b10;
    send_frame(8'h41, 7, 1'b1, 1'b1, 1, 1'b1);
    check_val("7e1_wr_count", wrCount - w0, 1);
    check_val("7e1_dout", lastDout, 10'h141);
  endtask

  task automatic test_8o2_framing_error;
    int w0;
    w0 = wrCount;
    d_num = 1'b1; s_num = 1'b1; par = 2'b01;
    send_frame(8'h3C, 8, 1'b1, 1'b1, 2, 1'b0);
    check_val("8o2_wr_count", wrCount - w0, 1);
    check_val("8o2_dout", lastDout, 10'h23C);
    s_num = 1'b0;
  endtask

  task automatic test_par_invalid;
    int w0;
    w0 = wrCount;
    d_num = 1'b1; s_num = 1'b0; par = 2'b11;
    send_frame(8'h0F, 8, 1'b0, 1'b0, 1, 1'b1);
    check_val("par11_wr_count", wrCount - w0, 1);
    check_val("par11_dout", lastDout, 10'h00F);
    par = 2'b00;
  endtask

  task automatic test_glitch;
    int w0;
    w0 = wrCount;
    rxd = 1'b0;
    wait_clks(4 * TICK_CLKS);
    check_val("glitch_busy_seen", rx_busy, 1'b1);
    rxd = 1'b1;
    wait_clks(20 * TICK_CLKS);
    check_val("glitch_busy_clear", rx_busy, 1'b0);
    check_val("glitch_no_wr", wrCount - w0, 0);
  endtask

  task automatic test_overrun;
    int w0, o0;
    w0 = wrCount; o0 = oeCount;
    d_num = 1'b1; par = 2'b00; rxfifo_full = 1'b1;
    send_frame(8'h55, 8, 1'b0, 1'b0, 1, 1'b1);
    check_val("ovr_oe_one_clk", oeCount - o0, 1);
    check_val("ovr_no_wr", wrCount - w0, 0);
    rxfifo_full = 1'b0;
  endtask

  task automatic test_break;
    int w0;
    w0 = wrCount;
    d_num = 1'b1; par = 2'b00; s_num = 1'b0;
    rxd = 1'b0;
    wait_clks(30 * BIT_CLKS);
    check_val("brk_busy_held", rx_busy, 1'b1);
    rxd = 1'b1;
    wait_clks(2 * BIT_CLKS);
    check_val("brk_one_word", wrCount - w0, 1);
    check_val("brk_dout", lastDout, 10'h200);
    check_val("brk_busy_clear", rx_busy, 1'b0);
    send_frame(8'h12, 8, 1'b0, 1'b0, 1, 1'b1);
    check_val("brk_next_count", wrCount - w0, 2);
    check_val("brk_next_dout", lastDout, 10'h012);
  endtask

  task automatic test_config_latch;
    int w0;
    logic [7:0] d;
    w0 = wrCount;
    d = 8'h80;
    d_num = 1'b1; par = 2'b00; s_num = 1'b0;
    send_bit(1'b0);
    send_bit(d[0]);
    d_num = 1'b0;
    for (int i = 1; i < 8; i++) send_bit(d[i]);
    send_bit(1'b1);
    wait_clks(2 * BIT_CLKS);
    check_val("latch_wr_count", wrCount - w0, 1);
    check_val("latch_dout", lastDout, 10'h080);
    d_num = 1'b1;
  endtask

  task automatic test_reset_mid_frame;
    int w0;
    logic [7:0] d;
    w0 = wrCount;
    d = 8'h81;
    d_num = 1'b1; par = 2'b00; s_num = 1'b0;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(d[i]);
    rxd = d[4];
    wait_clks(BIT_CLKS / 2);
    check_val("rstmid_busy_before", rx_busy, 1'b1);
    #3 n_rst = 1'b0;
    #1;
    check_val("rstmid_busy_now", rx_busy, 1'b0);
    check_val("rstmid_wr_now", rx_wr, 1'b0);
    check_val("rstmid_dout_now", rx_dout, 10'h000);
    rxd = 1'b1;
    wait_clks(10);
    n_rst = 1'b1;
    wait_clks(2 * BIT_CLKS);
    check_val("rstmid_no_partial", wrCount - w0, 0);
    send_frame(8'h81, 8, 1'b0, 1'b0, 1, 1'b1);
    check_val("rstmid_next_count", wrCount - w0, 1);
    check_val("rstmid_next_dout", lastDout, 10'h081);
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_7e1_parity_error();
    test_8o2_framing_error();
    test_par_invalid();
    test_glitch();
    test_overrun();
    test_break();
    test_config_latch();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
